// File: rtl/store_lane_packer_if.sv
// Store request and memory write-beat signals shared by the store lane packer
// and its environment.
//
// Handshake rules (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. Once the producer raises valid, it holds
// valid and every payload signal stable until that edge. The consumer may
// raise or drop ready freely.
interface store_lane_packer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  // Environment side: issues store requests and acts as the memory write port.
  modport master (
    output req_valid, req_addr, req_data, req_size, mem_wready,
    input  req_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, done, err
  );

  // Packer side.
  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_wready,
    output req_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, done, err
  );
endinterface

// File: rtl/store_lane_packer.sv
// Store lane packer: narrows rs2 to the store size and places it on the byte
// lanes of a word-aligned write bus. The bus also carries the byte strobes.
// A store that crosses a word boundary is issued as two beats. When
// misaligned stores are disabled, such a store is rejected with err instead.
module store_lane_packer #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  store_lane_packer_if.slave   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state;
  logic        split_q;
  logic [31:0] hi_addr;
  logic [31:0] hi_data;
  logic [3:0]  hi_strb;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] data_m;
  logic [7:0]  strb64;
  logic [63:0] data64;
  logic [31:0] base;
  logic        split;
  logic        reject;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign dbg_state     = state;

  // Lane placement of the incoming request. This is a 64-bit window, so a
  // store that crosses a word boundary spills into the upper half.
  always_comb begin
    off    = bus.req_addr[1:0];
    mask   = 4'b0000;
    data_m = 32'h0;
    case (bus.req_size)
      2'b00: begin mask = 4'b0001; data_m = {24'h0, bus.req_data[7:0]};  end
      2'b01: begin mask = 4'b0011; data_m = {16'h0, bus.req_data[15:0]}; end
      2'b10: begin mask = 4'b1111; data_m = bus.req_data;                end
      default: begin mask = 4'b0000; data_m = 32'h0;                     end
    endcase
    strb64 = {4'b0000, mask} << off;
    data64 = {32'h0, data_m} << {off, 3'b000};
    base   = {bus.req_addr[31:2], 2'b00};
    split  = |strb64[7:4];
    reject = (bus.req_size == 2'b11) || (split && !ALLOW_MISALIGNED);
  end

  // Beat sequencer. All bus outputs are registered. The second beat's payload
  // is captured at accept time, so beat 0 can stall without affecting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      split_q        <= 1'b0;
      hi_addr        <= 32'h0;
      hi_data        <= 32'h0;
      hi_strb        <= 4'h0;
      bus.mem_wvalid <= 1'b0;
      bus.mem_waddr  <= 32'h0;
      bus.mem_wdata  <= 32'h0;
      bus.mem_wstrb  <= 4'h0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (reject) begin
              bus.err <= 1'b1;
            end else begin
              state          <= BEAT0;
              split_q        <= split;
              hi_addr        <= base + 32'd4;
              hi_data        <= data64[63:32];
              hi_strb        <= strb64[7:4];
              bus.mem_wvalid <= 1'b1;
              bus.mem_waddr  <= base;
              bus.mem_wdata  <= data64[31:0];
              bus.mem_wstrb  <= strb64[3:0];
            end
          end
        end
        BEAT0: begin
          if (bus.mem_wready) begin
            if (split_q) begin
              state         <= BEAT1;
              bus.mem_waddr <= hi_addr;
              bus.mem_wdata <= hi_data;
              bus.mem_wstrb <= hi_strb;
            end else begin
              state          <= IDLE;
              bus.mem_wvalid <= 1'b0;
              bus.mem_wstrb  <= 4'h0;
              bus.done       <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (bus.mem_wready) begin
            state          <= IDLE;
            bus.mem_wvalid <= 1'b0;
            bus.mem_wstrb  <= 4'h0;
            bus.done       <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          bus.mem_wvalid <= 1'b0;
          bus.mem_wstrb  <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed bench for store_lane_packer: a vector table of single stores, plus
// hand-written sequences for stalls, back-to-back accepts, reset mid-store
// and the misaligned-reject build.
module tb_store_lane_packer;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  store_lane_packer_if bus ();
  store_lane_packer_if bus2 ();

  store_lane_packer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
  );

  store_lane_packer #(.ALLOW_MISALIGNED(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state(dbg_state2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected beats, packed as {addr, data, strb}
  logic [67:0] exp_q[$];

  typedef struct {
    string       name;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    bit          is_err;
    int          beats;
    logic [31:0] a0; logic [31:0] d0; logic [3:0] s0;
    logic [31:0] a1; logic [31:0] d1; logic [3:0] s1;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_data  = data;
  endtask

  // Runs one table vector with mem_wready held high. Outputs are sampled on
  // falling edges.
  task automatic run_vec(input vec_t v);
    logic [67:0] e;
    @(negedge clk);
    chk({v.name, " req_ready"}, {31'h0, bus.req_ready}, 32'd1);
    bus.mem_wready = 1'b1;
    drive_req(v.size, v.addr, v.data);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (v.is_err) begin
      chk({v.name, " err"}, {31'h0, bus.err}, 32'd1);
      chk({v.name, " wvalid"}, {31'h0, bus.mem_wvalid}, 32'd0);
      chk({v.name, " done"}, {31'h0, bus.done}, 32'd0);
    end else begin
      exp_q.push_back({v.a0, v.d0, v.s0});
      if (v.beats == 2) exp_q.push_back({v.a1, v.d1, v.s1});
      for (int b = 0; b < v.beats; b++) begin
        e = exp_q.pop_front();
        chk({v.name, " wvalid"}, {31'h0, bus.mem_wvalid}, 32'd1);
        chk({v.name, " waddr"}, bus.mem_waddr, e[67:36]);
        chk({v.name, " wdata"}, bus.mem_wdata, e[35:4]);
        chk({v.name, " wstrb"}, {28'h0, bus.mem_wstrb}, {28'h0, e[3:0]});
        chk({v.name, " no early done"}, {31'h0, bus.done}, 32'd0);
        @(negedge clk);
      end
      chk({v.name, " done"}, {31'h0, bus.done}, 32'd1);
      chk({v.name, " idle wvalid"}, {31'h0, bus.mem_wvalid}, 32'd0);
      chk({v.name, " idle wstrb"}, {28'h0, bus.mem_wstrb}, 32'd0);
      chk({v.name, " no err"}, {31'h0, bus.err}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{"sw_aligned", 2'b10, 32'h100, 32'hDEADBEEF, 1'b0, 1,
                32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h0, 4'h0};
    vecs[1] = '{"sb_off3", 2'b00, 32'h203, 32'h123456AB, 1'b0, 1,
                32'h200, 32'hAB000000, 4'b1000, 32'h0, 32'h0, 4'h0};
    vecs[2] = '{"sh_split", 2'b01, 32'h307, 32'h0000CAFE, 1'b0, 2,
                32'h304, 32'hFE000000, 4'b1000, 32'h308, 32'h000000CA, 4'b0001};
    vecs[3] = '{"sw_wrap", 2'b10, 32'hFFFFFFFE, 32'h11223344, 1'b0, 2,
                32'hFFFFFFFC, 32'h33440000, 4'b1100, 32'h0, 32'h00001122, 4'b0011};
    vecs[4] = '{"sh_off2", 2'b01, 32'h402, 32'hABCD1234, 1'b0, 1,
                32'h400, 32'h12340000, 4'b1100, 32'h0, 32'h0, 4'h0};
    vecs[5] = '{"sb_off1", 2'b00, 32'h501, 32'hFFFFFF5A, 1'b0, 1,
                32'h500, 32'h00005A00, 4'b0010, 32'h0, 32'h0, 4'h0};
    vecs[6] = '{"sw_off1", 2'b10, 32'h601, 32'hAABBCCDD, 1'b0, 2,
                32'h600, 32'hBBCCDD00, 4'b1110, 32'h604, 32'h000000AA, 4'b0001};
    vecs[7] = '{"sh_off0", 2'b01, 32'h700, 32'hFFFF8765, 1'b0, 1,
                32'h700, 32'h00008765, 4'b0011, 32'h0, 32'h0, 4'h0};
    vecs[8] = '{"size_rsvd", 2'b11, 32'h123, 32'h55555555, 1'b1, 0,
                32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[9] = '{"sw_off3", 2'b10, 32'h803, 32'h01020304, 1'b0, 2,
                32'h800, 32'h04000000, 4'b1000, 32'h804, 32'h00010203, 4'b0111};

    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_data = 32'h0;
    bus.req_size = 2'b00; bus.mem_wready = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_addr = 32'h0; bus2.req_data = 32'h0;
    bus2.req_size = 2'b00; bus2.mem_wready = 1'b1;
    rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst wvalid", {31'h0, bus.mem_wvalid}, 32'd0);
    chk("rst waddr", bus.mem_waddr, 32'h0);
    chk("rst wdata", bus.mem_wdata, 32'h0);
    chk("rst wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    chk("rst done", {31'h0, bus.done}, 32'd0);
    chk("rst err", {31'h0, bus.err}, 32'd0);
    chk("rst req_ready low", {31'h0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("post rst state", {30'h0, dbg_state}, 32'd0);

    // Table vectors
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Stall: wready low for 5 cycles in BEAT0, a competing request is ignored
    @(negedge clk);
    bus.mem_wready = 1'b0;
    drive_req(2'b10, 32'h900, 32'hCAFEBABE);
    @(negedge clk);
    drive_req(2'b10, 32'h40, 32'h11111111);
    for (int i = 0; i < 5; i++) begin
      chk("stall wvalid", {31'h0, bus.mem_wvalid}, 32'd1);
      chk("stall waddr", bus.mem_waddr, 32'h900);
      chk("stall wdata", bus.mem_wdata, 32'hCAFEBABE);
      chk("stall wstrb", {28'h0, bus.mem_wstrb}, 32'hF);
      chk("stall req_ready", {31'h0, bus.req_ready}, 32'd0);
      chk("stall done", {31'h0, bus.done}, 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.mem_wready = 1'b1;
    @(negedge clk);
    chk("stall done", {31'h0, bus.done}, 32'd1);
    chk("stall end wvalid", {31'h0, bus.mem_wvalid}, 32'd0);
    @(negedge clk);
    chk("ignored req no beat", {31'h0, bus.mem_wvalid}, 32'd0);
    chk("single done", {31'h0, bus.done}, 32'd0);

    // Back-to-back: new request accepted in the cycle done pulses
    drive_req(2'b00, 32'h10, 32'h000000AA);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b beat a", bus.mem_waddr, 32'h10);
    @(negedge clk);
    chk("b2b done a", {31'h0, bus.done}, 32'd1);
    chk("b2b ready at done", {31'h0, bus.req_ready}, 32'd1);
    drive_req(2'b01, 32'h22, 32'h00004321);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b beat b wvalid", {31'h0, bus.mem_wvalid}, 32'd1);
    chk("b2b beat b waddr", bus.mem_waddr, 32'h20);
    chk("b2b beat b wdata", bus.mem_wdata, 32'h43210000);
    chk("b2b beat b wstrb", {28'h0, bus.mem_wstrb}, 32'hC);
    @(negedge clk);
    chk("b2b done b", {31'h0, bus.done}, 32'd1);

    // Reset during BEAT1 abandons the store without done
    @(negedge clk);
    drive_req(2'b01, 32'h307, 32'h0000CAFE);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst-mid beat0 wstrb", {28'h0, bus.mem_wstrb}, 32'h8);
    @(negedge clk);
    chk("rst-mid beat1 waddr", bus.mem_waddr, 32'h308);
    chk("rst-mid state", {30'h0, dbg_state}, 32'd2);
    bus.mem_wready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst-mid wvalid", {31'h0, bus.mem_wvalid}, 32'd0);
    chk("rst-mid wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    chk("rst-mid done", {31'h0, bus.done}, 32'd0);
    rst = 1'b0;
    bus.mem_wready = 1'b1;
    @(negedge clk);
    chk("rst-mid req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("rst-mid no done", {31'h0, bus.done}, 32'd0);

    // Misaligned-reject build: split store errors, aligned store still works
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_size = 2'b01;
    bus2.req_addr = 32'h307; bus2.req_data = 32'h0000CAFE;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    chk("nomis err", {31'h0, bus2.err}, 32'd1);
    chk("nomis wvalid", {31'h0, bus2.mem_wvalid}, 32'd0);
    chk("nomis req_ready", {31'h0, bus2.req_ready}, 32'd1);
    bus2.req_valid = 1'b1; bus2.req_size = 2'b01;
    bus2.req_addr = 32'h306; bus2.req_data = 32'h0000BEEF;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    chk("nomis ok err", {31'h0, bus2.err}, 32'd0);
    chk("nomis ok wdata", bus2.mem_wdata, 32'hBEEF0000);
    chk("nomis ok wstrb", {28'h0, bus2.mem_wstrb}, 32'hC);
    @(negedge clk);
    chk("nomis ok done", {31'h0, bus2.done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
